path_sequencer: RTL

PATH_SEQUENCER -- requirements
Module: path_sequencer

---
 rtl/path_sequencer_pkg.sv | 48 ++++
 rtl/seq_timeout.sv | 32 +++
 rtl/path_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/path_sequencer_pkg.sv
// Shared encodings for the path sequencer: FSM states, decoded path codes,
// PC-select codes and the default wait timeout.
package path_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_PCUPD  = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam logic [3:0] PATH_MFHI = 4'b0000;
  localparam logic [3:0] PATH_ALU  = 4'b0001;
  localparam logic [3:0] PATH_LW   = 4'b0010;
  localparam logic [3:0] PATH_SW   = 4'b0011;
  localparam logic [3:0] PATH_BEQ  = 4'b0100;
  localparam logic [3:0] PATH_J    = 4'b0101;
  localparam logic [3:0] PATH_JAL  = 4'b0110;
  localparam logic [3:0] PATH_MULT = 4'b0111;
  localparam logic [3:0] PATH_JR   = 4'b1000;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_RS     = 2'b11;

  localparam int TIMEOUT_CYCLES_DEFAULT = 32;

  // Next-PC source for a completed instruction of the given path.
  function automatic logic [1:0] pc_sel_for(input logic [3:0] path, input logic zero);
    logic [1:0] sel;
    case (path)
      PATH_BEQ: begin
        if (zero) sel = PC_SEL_BRANCH;
        else      sel = PC_SEL_SEQ;
      end
      PATH_J, PATH_JAL: sel = PC_SEL_JUMP;
      PATH_JR:          sel = PC_SEL_RS;
      default:          sel = PC_SEL_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Wait-cycle counter for the sequencer's handshake states; expired marks the
// last permitted wait cycle of the current state.
module seq_timeout
  import path_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_r;

  // Count wait cycles, saturating at the limit; clear wins over count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (count_en && !expired) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign expired = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/path_sequencer.sv
// Multi-cycle instruction sequencer: Moore FSM with registered stage enables.
// Define PATH_SEQ_PERF_CNT_EN to build the cycle/instruction counters.
module path_sequencer
  import path_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decoder_done,
  input  logic [3:0]  path_index,
  input  logic        alu_zero,
  input  logic        alu_done,
  input  logic        mem_ready,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        alu_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        instr_done,
  output logic        busy,
  output logic        err,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  state_e     state_r, state_nxt_s;
  logic [3:0] path_r, path_nxt_s;
  logic       zero_r, zero_nxt_s;
  logic       entered_r;
  logic       expired_s;
  logic       wait_clear_s;
  logic       wait_count_s;

  function automatic state_e route(input logic [3:0] path);
    state_e nxt;
    case (path)
      PATH_ALU, PATH_LW, PATH_SW, PATH_BEQ, PATH_MULT: nxt = ST_EXEC;
      PATH_J, PATH_JR:                                 nxt = ST_PCUPD;
      PATH_JAL, PATH_MFHI:                             nxt = ST_WB;
      default:                                         nxt = ST_ERR;
    endcase
    return nxt;
  endfunction

  assign wait_clear_s = (state_nxt_s != state_r);
  assign wait_count_s = state_r inside {ST_DECODE, ST_EXEC, ST_MEM};

  seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wait_clear_s),
    .count_en (wait_count_s),
    .expired  (expired_s)
  );

  // Next-state and next-latch logic.
  always_comb begin
    state_nxt_s = state_r;
    path_nxt_s  = path_r;
    zero_nxt_s  = zero_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_FETCH;
        else       state_nxt_s = ST_IDLE;
      end
      ST_FETCH: state_nxt_s = ST_DECODE;
      ST_DECODE: begin
        // decoder_done seen on the entry cycle is left over from the last instruction
        if (decoder_done && !entered_r) begin
          path_nxt_s  = path_index;
          state_nxt_s = route(path_index);
        end else if (expired_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_DECODE;
        end
      end
      ST_EXEC: begin
        if (path_r == PATH_BEQ) zero_nxt_s = alu_zero;
        else                    zero_nxt_s = zero_r;
        case (path_r)
          PATH_ALU:         state_nxt_s = ST_WB;
          PATH_LW, PATH_SW: state_nxt_s = ST_MEM;
          PATH_MULT: begin
            if (alu_done)       state_nxt_s = ST_PCUPD;
            else if (expired_s) state_nxt_s = ST_ERR;
            else                state_nxt_s = ST_EXEC;
          end
          default: state_nxt_s = ST_PCUPD;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (path_r == PATH_LW) state_nxt_s = ST_WB;
          else                   state_nxt_s = ST_PCUPD;
        end else if (expired_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: state_nxt_s = ST_PCUPD;
      ST_PCUPD: begin
        if (start) state_nxt_s = ST_FETCH;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ERR:  state_nxt_s = ST_ERR;
      default: state_nxt_s = ST_ERR;
    endcase
  end

  // State, latches and outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      path_r     <= 4'b0000;
      zero_r     <= 1'b0;
      entered_r  <= 1'b0;
      fetch_en   <= 1'b0;
      decode_en  <= 1'b0;
      alu_en     <= 1'b0;
      mem_en     <= 1'b0;
      wb_en      <= 1'b0;
      pc_en      <= 1'b0;
      instr_done <= 1'b0;
      pc_sel     <= PC_SEL_SEQ;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      path_r     <= path_nxt_s;
      zero_r     <= zero_nxt_s;
      entered_r  <= wait_clear_s;
      fetch_en   <= (state_nxt_s == ST_FETCH);
      decode_en  <= (state_nxt_s == ST_DECODE);
      alu_en     <= (state_nxt_s == ST_EXEC);
      mem_en     <= (state_nxt_s == ST_MEM);
      wb_en      <= (state_nxt_s == ST_WB);
      pc_en      <= (state_nxt_s == ST_PCUPD);
      instr_done <= (state_nxt_s == ST_PCUPD);
      pc_sel     <= (state_nxt_s == ST_PCUPD) ? pc_sel_for(path_nxt_s, zero_nxt_s) : PC_SEL_SEQ;
      busy       <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_ERR);
      err        <= (state_nxt_s == ST_ERR);
    end
  end

`ifdef PATH_SEQ_PERF_CNT_EN
  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (busy)       cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule
